// File: rtl/alu_mc_if.sv
// Request/response bundle between the operand stage, the multi-cycle ALU and writeback.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             shift_cout;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic [3:0]       nzcv;
    logic             op_err;

    modport master (
        output in_valid, alu_op, a, b, shift_cout, set_flags, out_ready,
        input  in_ready, out_valid, f, nzcv, op_err
    );

    modport slave (
        input  in_valid, alu_op, a, b, shift_cout, set_flags, out_ready,
        output in_ready, out_valid, f, nzcv, op_err
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle data-processing ops, iterative MUL/UDIV, owns NZCV.
// Flags commit only when the result is handed off to writeback.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave io
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [4:0]       OP_MUL = 5'h10;
    localparam logic [4:0]       OP_DIV = 5'h11;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FOUR   = WIDTH'(4);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d, a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [1:0]       cv_q, cv_d;
    logic             err_q, err_d, sf_q, sf_d;

    logic [WIDTH-1:0] x, y, lres, alu_f;
    logic [WIDTH:0]   sum;
    logic             cin, arith, ill, ovf;
    logic [1:0]       alu_cv;

    // Subtracts are x + ~y + cin so C is NOT borrow; RSB/RSC swap the operands.
    always_comb begin
        x     = io.a;
        y     = io.b;
        cin   = 1'b0;
        arith = 1'b0;
        ill   = 1'b0;
        lres  = '0;
        case (io.alu_op)
            5'h00: lres = io.a & io.b;
            5'h01: lres = io.a ^ io.b;
            5'h02: begin y = ~io.b; cin = 1'b1; arith = 1'b1; end
            5'h03: begin x = io.b; y = ~io.a; cin = 1'b1; arith = 1'b1; end
            5'h04: arith = 1'b1;
            5'h05: begin cin = nzcv_q[1]; arith = 1'b1; end
            5'h06: begin y = ~io.b; cin = nzcv_q[1]; arith = 1'b1; end
            5'h07: begin x = io.b; y = ~io.a; cin = nzcv_q[1]; arith = 1'b1; end
            5'h08: lres = io.a;
            5'h0A: begin y = ~io.b; cin = 1'b1; arith = 1'b1; end
            5'h0C: lres = io.a | io.b;
            5'h0D: lres = io.b;
            5'h0E: lres = io.a & ~io.b;
            5'h0F: lres = ~io.b;
            default: ill = 1'b1;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        if (ill)
            alu_f = '0;
        else if (!arith)
            alu_f = lres;
        else if (io.alu_op == 5'h0A)
            alu_f = sum[WIDTH-1:0] + FOUR;
        else
            alu_f = sum[WIDTH-1:0];
        alu_cv = arith ? {sum[WIDTH], ovf} : {io.shift_cout, nzcv_q[0]};
    end

    logic [WIDTH:0] rem_sh;
    logic           qbit;

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nzcv_d  = nzcv_q;
        cv_d    = cv_q;
        err_d   = err_q;
        sf_d    = sf_q;
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        qbit    = (rem_sh >= {1'b0, b_q});
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d   = io.a;
                    b_d   = io.b;
                    sf_d  = io.set_flags;
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    cv_d  = nzcv_q[1:0];
                    if (io.alu_op == OP_MUL) begin
                        state_d = MUL;
                    end else if (io.alu_op == OP_DIV) begin
                        state_d = DIV;
                    end else begin
                        f_d     = alu_f;
                        err_d   = ill;
                        cv_d    = alu_cv;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    f_d     = acc_d;
                    state_d = DONE;
                end
            end
            DIV: begin
                if (b_q == '0) begin
                    f_d     = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // a_q shifts out dividend bits and collects quotient bits.
                    acc_d = qbit ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        f_d     = a_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    if (sf_q && !err_q)
                        nzcv_d = {f_q[WIDTH-1], (f_q == '0), cv_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            f_q     <= '0;
            err_q   <= 1'b0;
            nzcv_q  <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            err_q   <= err_d;
            nzcv_q  <= nzcv_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        cv_q  <= cv_d;
        sf_q  <= sf_d;
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.f         = f_q;
    assign io.op_err    = err_q;
    assign io.nzcv      = nzcv_q;
endmodule
